// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754 multiplier with RNE rounding, exception flags and valid/ready flow control
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic [3:0]             flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, adv;
  logic v1_d, v1_q, v2_d, v2_q, out_valid_d, out_valid_q;
  logic sign1_d, sign1_q, sign2_d, sign2_q;
  logic [2:0] cls1_d, cls1_q, cls2_d, cls2_q;
  logic signed [EW-1:0] exp1_d, exp1_q, exp2_d, exp2_q, e_n, e_f;
  logic [MAN_W:0] ma1_d, ma1_q, mb1_d, mb1_q;
  logic [PW-1:0] prod2_d, prod2_q;
  logic [PW-2:0] nrm;
  logic [MAN_W-1:0] frac, frac_r;
  logic g, r, s, up;
  logic [W-1:0] product_d, product_q;
  logic [3:0] flags_d, flags_q;
  assign {ea, fa} = a[W-2:0];
  assign {eb, fb} = b[W-2:0];
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign a_inf = &ea && fa == '0;
  assign b_inf = &eb && fb == '0;
  assign a_nan = &ea && fa != '0;
  assign b_nan = &eb && fb != '0;
  assign adv = ~(out_valid_q & ~out_ready);
  assign in_ready = adv;
  assign out_valid = out_valid_q;
  assign product = product_q;
  assign flags = flags_q;
  // Stage 1: classify operands (cls = {nan, inf, zero}, subnormals count as zero) and sum exponents.
  always_comb begin
    v1_d = in_valid;
    sign1_d = a[W-1] ^ b[W-1];
    cls1_d[2] = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    cls1_d[1] = (a_inf | b_inf) & ~cls1_d[2];
    cls1_d[0] = (a_zero | b_zero) & ~cls1_d[2];
    exp1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    ma1_d = {1'b1, fa};
    mb1_d = {1'b1, fb};
  end
  // Stage 2: full-width significand product.
  always_comb begin
    v2_d = v1_q;
    sign2_d = sign1_q;
    cls2_d = cls1_q;
    exp2_d = exp1_q;
    prod2_d = PW'(ma1_q) * PW'(mb1_q);
  end
  // Stage 3: normalise, round to nearest even, then resolve specials and range exceptions.
  always_comb begin
    nrm = prod2_q[PW-1] ? prod2_q[PW-2:0] : {prod2_q[PW-3:0], 1'b0};
    frac = nrm[PW-2 -: MAN_W];
    g = nrm[MAN_W];
    r = nrm[MAN_W-1];
    s = |nrm[MAN_W-2:0];
    up = g & (r | s | frac[0]);
    e_n = exp2_q + EW'(prod2_q[PW-1]);
    {e_f, frac_r} = {e_n, frac} + (EW + MAN_W)'(up);
    out_valid_d = v2_q;
    product_d = cls2_q[2] ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}}
              : (cls2_q[1] || e_f >= EMAX) ? {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
              : (cls2_q[0] || e_f[EW-1] || e_f == '0) ? {sign2_q, {(W - 1){1'b0}}}
              : {sign2_q, e_f[EXP_W-1:0], frac_r};
    flags_d = cls2_q[2] ? 4'b1000
            : |cls2_q[1:0] ? 4'b0000
            : e_f >= EMAX ? 4'b0101
            : (e_f[EW-1] || e_f == '0) ? 4'b0011
            : {3'b000, g | r | s};
  end
  // Valid bits and the output register clear on reset; the whole pipe advances as one unless stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      out_valid_q <= 1'b0;
      product_q <= '0;
      flags_q <= '0;
    end else if (adv) begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      out_valid_q <= out_valid_d;
      product_q <= product_d;
      flags_q <= flags_d;
    end
  end
  // Payload registers carry no reset; the valid bits say whether they mean anything.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q <= sign1_d;
      cls1_q <= cls1_d;
      exp1_q <= exp1_d;
      ma1_q <= ma1_d;
      mb1_q <= mb1_d;
      sign2_q <= sign2_d;
      cls2_q <= cls2_d;
      exp2_q <= exp2_d;
      prod2_q <= prod2_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and randomized checks of fp_mul_pipe against an arithmetic reference model
module tb_fp_mul_pipe;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, product;
  logic [3:0] flags;
  logic [35:0] exp_q[$];
  logic [35:0] got;
  logic held;
  logic [39:0] held_v;
  int n_cmp = 0, n_err = 0, outs = 0;
  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .flags(flags)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [39:0] got_v, input logic [39:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask
  // Real-valued reference: exact product of significands, RNE to 24 bits, flush on range exceptions.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic sg, az, bz, ai, bi, an, bn, inx;
    real m, sc, fr;
    int e, ip;
    sg = x[31] ^ y[31];
    az = x[30:23] == 8'h00;
    bz = y[30:23] == 8'h00;
    ai = x[30:23] == 8'hFF && x[22:0] == 23'h0;
    bi = y[30:23] == 8'hFF && y[22:0] == 23'h0;
    an = x[30:23] == 8'hFF && x[22:0] != 23'h0;
    bn = y[30:23] == 8'hFF && y[22:0] != 23'h0;
    if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
    if (ai || bi) return {4'b0000, sg, 8'hFF, 23'h0};
    if (az || bz) return {4'b0000, sg, 31'h0};
    m = real'(32'({1'b1, x[22:0]})) * real'(32'({1'b1, y[22:0]}));
    e = int'(x[30:23]) + int'(y[30:23]) - 173;
    while (m >= 2.0) begin
      m = m / 2.0;
      e++;
    end
    sc = m * 8388608.0;
    ip = $rtoi(sc);
    fr = sc - real'(ip);
    inx = fr != 0.0;
    if (fr > 0.5 || (fr == 0.5 && ip[0])) ip++;
    if (ip == (1 << 24)) begin
      ip = 1 << 23;
      e++;
    end
    if (e >= 255) return {4'b0101, sg, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, sg, 31'h0};
    return {3'b000, inx, sg, e[7:0], ip[22:0]};
  endfunction
  function automatic logic [31:0] rnd();
    logic [31:0] v = $urandom;
    v[30:23] = 8'($urandom_range(64, 190));
    return v;
  endfunction
  // Scoreboard: records accepted operands, checks every delivered result, hold-during-stall and in_ready.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 0;
    end else begin
      chk("in_ready", 40'(in_ready), 40'(!(out_valid && !out_ready)));
      if (held) chk("hold", 40'({out_valid, flags, product}), held_v);
      if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_out", 40'(1), 40'(0));
        else chk("result", 40'({flags, product}), 40'(exp_q.pop_front()));
        outs++;
      end
      held = out_valid && !out_ready;
      held_v = 40'({out_valid, flags, product});
    end
  end
  task automatic one(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [35:0] ev, output logic [35:0] res);
    int lat = 1;
    a = x;
    b = y;
    in_valid = 1;
    out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      #1 lat++;
    end
    res = {flags, product};
    chk({tag, "_lat"}, 40'(lat), 40'(3));
    chk(tag, 40'(res), 40'(ev));
    @(posedge clk);
    #1;
  endtask
  task automatic stream(input int n, input int mode);
    int sent = 0, cyc = 0, o0 = outs;
    logic acc;
    a = rnd();
    b = rnd();
    while ((sent < n || exp_q.size() != 0) && cyc < 20 * n + 50) begin
      in_valid = sent < n && (mode != 2 || $urandom_range(0, 3) != 0);
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc % 3 == 0 : 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        a = rnd();
        b = rnd();
      end
      cyc++;
    end
    in_valid = 0;
    out_ready = 1;
    chk("stream_sent", 40'(sent), 40'(n));
    chk("stream_outs", 40'(outs - o0), 40'(n));
  endtask
  initial begin
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    a = 0;
    b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 40'({out_valid, flags, product}), 40'(0));
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready", 40'(in_ready), 40'(1));
    @(posedge clk);
    #1;
    one("basic", 32'h3FC00000, 32'h40000000, {4'h0, 32'h40400000}, got);
    one("mixed", 32'hBE99999A, 32'h43FA2000, ref_mul(32'hBE99999A, 32'h43FA2000), got);
    chk("mixed_sign", 40'(got[31]), 40'(1));
    chk("mixed_inexact", 40'(got[32]), 40'(1));
    one("round", 32'h3F800001, 32'h3F800001, {4'h1, 32'h3F800002}, got);
    one("tie_even", 32'h3F800001, 32'h3FC00000, {4'h1, 32'h3FC00002}, got);
    one("inf_x_zero", 32'h7F800000, 32'h00000000, {4'h8, 32'h7FC00000}, got);
    one("nan_in", 32'h7FA00001, 32'h3F800000, {4'h8, 32'h7FC00000}, got);
    one("inf_x_neg", 32'h7F800000, 32'hC0000000, {4'h0, 32'hFF800000}, got);
    one("overflow", 32'h7F7FFFFF, 32'h40000000, {4'h5, 32'h7F800000}, got);
    one("underflow", 32'h00800000, 32'h00800000, {4'h3, 32'h00000000}, got);
    one("neg_zero", 32'h80000000, 32'h3F800000, {4'h0, 32'h80000000}, got);
    one("subnormal", 32'h00000123, 32'hC0000000, {4'h0, 32'h80000000}, got);
    one("carry_round", 32'h3FFFFFFF, 32'h3F800001, {4'h1, 32'h40000000}, got);
    stream(8, 1);
    out_ready = 1;
    in_valid = 1;
    repeat (3) begin
      a = rnd();
      b = rnd();
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    out_ready = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_valid", 40'(out_valid), 40'(0));
    repeat (5) begin
      @(negedge clk);
      chk("rst_stale", 40'(out_valid), 40'(0));
    end
    @(posedge clk);
    #1 out_ready = 1;
    one("after_rst", 32'h3F800000, 32'h40000000, {4'h0, 32'h40000000}, got);
    stream(6000, 0);
    stream(4000, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
